rr_mux_select: RTL and testbench
================================

# rr_mux_select

Parametrised N-channel, WIDTH-bit selector with a registered output stage and valid/ready handshakes on every channel and on the output. Arbitrates among requesting channels in round-robin or fixed-priority mode, forwarding one word per cycle at full throughput. Successor to the single-select 3-bit gating mux in the datapath; sits between multiple producers and one shared consumer.

## Interface
- WIDTH, 3: data width per channel.
- CHANNELS, 4: number of input channels, ≥1.
- IDXW, $clog2(CHANNELS) (min 1): width of grant index.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  channel i offers a word.
- in_ready  output  CHANNELS  channel i's word is accepted this cycle.
- priority_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data this cycle.
- grant_idx  output  IDXW  channel index of the word in out_data.

## Operation
- load_en = !out_valid || out_ready (register empty or being drained).
- Arbitration (combinational, every cycle):
  - Round-robin: search in_valid starting at last_grant+1, wrapping modulo CHANNELS; first set bit wins.
  - Fixed priority: lowest-index set bit of in_valid wins.
- in_ready[i] = load_en && any(in_valid) && winner == i; at most one bit high; zero when no request or when load_en is low.
- On clock edge with load_en:
  - Winner exists: out_data <= winner's word, grant_idx <= winner, out_valid <= 1, last_grant <= winner.
  - No winner: out_valid <= 0; out_data per Configuration; grant_idx and last_grant unchanged.
- load_en low: out_data, grant_idx, out_valid, last_grant held.
- last_grant updates only on an accepted input transfer, in both modes; switching mode does not reset it.
- Producers hold in_valid and in_data stable until in_ready; the block does not lock a grant across cycles, so a withdrawn request simply drops from arbitration.
- CHANNELS = 1: degenerates to a one-entry registered pipe stage; grant_idx constant 0.

## Timing
- Reset (async assert, takes effect immediately): out_valid 0, out_data 0, grant_idx 0, last_grant CHANNELS-1 (channel 0 has first round-robin priority). in_ready all 0 while rst is high.
- Latency: input accepted in cycle n appears on out_data/out_valid in cycle n+1.
- Throughput: one word per cycle when out_ready is held high.
- Backpressure: out_ready low with out_valid high holds all outputs stable and forces in_ready to 0.
- Simultaneous drain and load: out_valid && out_ready together with a new winner replaces the word with no bubble.
- priority_mode change applies to the arbitration in the same cycle it is sampled.
- Reset mid-transfer: pending output word is discarded; arbitration restarts from channel 0.

## Configuration
- RR_MUX_ZERO_GATE_EN defined: out_data is forced to 0 whenever out_valid is 0 (registered to 0 on any load with no winner). This matches the zero-when-deselected behaviour of the existing gating mux.
- Undefined: out_data holds the last transferred word when out_valid falls (lower toggle power). Reset value 0 in both builds.

## Test plan
- Reset, then all in_valid=4'b1111 with distinct data 1,2,3,4 and out_ready=1, priority_mode=0 -> grant_idx sequence 0,1,2,3,0, one per cycle, out_data 1,2,3,4,1, with out_valid continuously 1.
- Same stimulus with priority_mode=1 -> grant_idx 0 every cycle, in_ready=4'b0001 each cycle.
- Single requester channel 2 (data 3'b110) held valid, out_ready=1 -> back-to-back grants to channel 2, out_data 3'b110 every cycle.
- out_ready=0 for 3 cycles with out_valid=1 -> out_data/grant_idx stable, in_ready=0; out_ready=1 -> next word loaded the following cycle with no bubble.
- All in_valid drop after one transfer of 3'b111 -> out_valid falls next cycle; out_data 0 with RR_MUX_ZERO_GATE_EN, 3'b111 without.
- Assert rst while out_valid=1 with grant_idx=2 -> out_valid 0, out_data 0, grant_idx 0 immediately; after release with all channels requesting, channel 0 is granted first.

Source files
------------

// File: rtl/rr_mux_select.sv
// N-channel valid/ready selector with round-robin or fixed-priority arbitration and a registered output.
// Define RR_MUX_ZERO_GATE_EN to force out_data to zero whenever out_valid is low.
module rr_mux_select #(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 4,
  parameter int IDXW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      priority_mode,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDXW-1:0]           grant_idx
);

  logic [WIDTH-1:0] out_data_q,   out_data_d;
  logic             out_valid_q,  out_valid_d;
  logic [IDXW-1:0]  grant_idx_q,  grant_idx_d;
  logic [IDXW-1:0]  last_grant_q, last_grant_d;

  logic             load_en;
  logic             any_req;
  logic             found_hi;
  logic             found_lo;
  logic [IDXW-1:0]  idx_hi;
  logic [IDXW-1:0]  idx_lo;
  logic [IDXW-1:0]  winner;
  logic [WIDTH-1:0] win_data;

  // Round-robin wrap is resolved as two scans: lowest requester above
  // last_grant, falling back to lowest requester overall.
  always_comb begin
    any_req  = |in_valid;
    load_en  = !out_valid_q || out_ready;
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int unsigned j = 0; j < CHANNELS; j++) begin
      if (in_valid[j] && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = IDXW'(j);
      end
      if (in_valid[j] && !found_hi && (j > 32'(last_grant_q))) begin
        found_hi = 1'b1;
        idx_hi   = IDXW'(j);
      end
    end
    winner = (!priority_mode && found_hi) ? idx_hi : idx_lo;

    win_data = '0;
    in_ready = '0;
    for (int unsigned j = 0; j < CHANNELS; j++) begin
      if (32'(winner) == j) begin
        win_data    = in_data[j*WIDTH +: WIDTH];
        in_ready[j] = load_en && any_req && !rst;
      end
    end
  end

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    if (load_en) begin
      if (any_req) begin
        out_data_d   = win_data;
        out_valid_d  = 1'b1;
        grant_idx_d  = winner;
        last_grant_d = winner;
      end else begin
        out_valid_d = 1'b0;
`ifdef RR_MUX_ZERO_GATE_EN
        out_data_d  = '0;
`else
        out_data_d  = out_data_q;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      grant_idx_q  <= '0;
      last_grant_q <= IDXW'(CHANNELS - 1);
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_rr_mux_select.sv
// Directed self-checking bench for rr_mux_select (4 channels, 3-bit data).
module tb_rr_mux_select;

  logic        clk;
  logic        rst;
  logic [11:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        priority_mode;
  logic [2:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  grant_idx;

  int n_chk  = 0;
  int n_pass = 0;

  rr_mux_select #(.WIDTH(3), .CHANNELS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .priority_mode (priority_mode),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .grant_idx     (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [11:0] pack(input logic [2:0] d0, input logic [2:0] d1,
                                       input logic [2:0] d2, input logic [2:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] g, input logic [2:0] d);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_grant"}, 32'(grant_idx), 32'(g));
    check({tag, "_data"},  32'(out_data),  32'(d));
  endtask

  logic [2:0] drop_exp;

  initial begin
    rst           = 1'b0;
    in_valid      = 4'b1111;
    in_data       = pack(3'd1, 3'd2, 3'd3, 3'd4);
    priority_mode = 1'b0;
    out_ready     = 1'b1;
    #1 rst = 1'b1;
    #1;
    check_out("reset", 1'b0, 2'd0, 3'd0);
    check("reset_in_ready", 32'(in_ready), 32'h0);
    tick();
    check_out("reset_hold", 1'b0, 2'd0, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Round-robin with all channels requesting
    check("rr_in_ready_first", 32'(in_ready), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("rr", 1'b1, 2'(i % 4), 3'((i % 4) + 1));
      check("rr_in_ready", 32'(in_ready), 32'(1 << ((i + 1) % 4)));
    end

    // Fixed priority: channel 0 always wins
    priority_mode = 1'b1;
    #1;
    check("fp_in_ready_first", 32'(in_ready), 32'b0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("fp", 1'b1, 2'd0, 3'd1);
      check("fp_in_ready", 32'(in_ready), 32'b0001);
    end

    // Single requester on channel 2
    priority_mode = 1'b0;
    in_valid      = 4'b0100;
    in_data       = pack(3'd0, 3'd0, 3'b110, 3'd0);
    #1;
    check("single_in_ready", 32'(in_ready), 32'b0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("single", 1'b1, 2'd2, 3'b110);
    end

    // Backpressure: outputs frozen, in_ready forced low
    in_valid  = 4'b1111;
    in_data   = pack(3'd1, 3'd2, 3'd3, 3'd4);
    out_ready = 1'b0;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("bp_hold", 1'b1, 2'd2, 3'b110);
      check("bp_hold_in_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'b1000);
    tick();
    check_out("bp_release", 1'b1, 2'd3, 3'd4);

    // Requests drop after one transfer of 3'b111
    in_valid = 4'b0001;
    in_data  = pack(3'b111, 3'd0, 3'd0, 3'd0);
    #1;
    check("drop_in_ready", 32'(in_ready), 32'b0001);
    tick();
    check_out("drop_load", 1'b1, 2'd0, 3'b111);
    in_valid = 4'b0000;
    #1;
    check("drop_idle_in_ready", 32'(in_ready), 32'h0);
    tick();
`ifdef RR_MUX_ZERO_GATE_EN
    drop_exp = 3'b000;
`else
    drop_exp = 3'b111;
`endif
    check_out("drop_empty", 1'b0, 2'd0, drop_exp);

    // Reset while holding a word from channel 2
    in_valid = 4'b0100;
    in_data  = pack(3'd0, 3'd0, 3'b101, 3'd0);
    #1;
    check("mid_in_ready", 32'(in_ready), 32'b0100);
    tick();
    check_out("mid_load", 1'b1, 2'd2, 3'b101);
    rst = 1'b1;
    #1;
    check_out("mid_reset", 1'b0, 2'd0, 3'd0);
    check("mid_reset_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 4'b1111;
    in_data  = pack(3'd1, 3'd2, 3'd3, 3'd4);
    #1;
    check("post_reset_in_ready", 32'(in_ready), 32'b0001);
    tick();
    check_out("post_reset", 1'b1, 2'd0, 3'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
